dut_fsm: RTL and testbench
==========================

DUT_FSM -- requirements
Module: dut_fsm

Interface
REQ-001 Parameter N, default 4, data width in bits.
REQ-002 Parameter LIM, default 14, highest legal sequence value; must be below 2^N-1.
REQ-003 clk_i  input  1  single clock, all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 data_i  input  N  incoming sequence value, sampled every rising clk_i edge.
REQ-006 data_o  output  N  registered checked value, or the error code 2^N-1 (4'hF at N=4).

Function
REQ-007 Latency: data_o SHALL be registered, updated exactly 1 clock after data_i is sampled.
REQ-008 States SHALL be S_INIT, S_TRACK and S_ERR; a register prev holds the last accepted value.
REQ-009 S_INIT: data_i <= LIM -> data_o=data_i, prev=data_i, go S_TRACK; data_i > LIM -> data_o=ERR code, stay S_INIT.
REQ-010 S_TRACK legal input: data_i == prev (hold) or data_i == prev+1, with wrap from LIM to 0 -> data_o=data_i, prev=data_i, stay S_TRACK.
REQ-011 S_TRACK illegal input: any other value, including data_i > LIM -> data_o=ERR code, prev unchanged, go S_ERR.
REQ-012 S_ERR: data_i <= LIM -> resynchronise with data_o=data_i, prev=data_i, go S_TRACK; otherwise data_o=ERR code, stay S_ERR.
REQ-013 Chaining: an ERR code at data_i is always illegal, so instances in series propagate the error one cycle per stage.
REQ-014 TMR: the state, prev and data_o registers SHALL each be triplicated and bitwise majority-voted.
REQ-015 The voted value SHALL be fed back to all three replicas every cycle, so a single-replica upset is scrubbed in 1 cycle and never reaches data_o.
REQ-016 Companion m_pat_gen (N=4, LIM=14; ports clk_i, rst_i, inc_i, inj_err_i, cnt_o, warn_o):
- TMR counter, +1 per clock while inc_i=1, wrapping from LIM to 0.
- inj_err_i=1 adds an extra +1 to replica 0 only.
- cnt_o is the voted value.
- warn_o=1 in any cycle where the replicas disagree; otherwise 0.

Reset
REQ-017 rst_i low SHALL asynchronously force all replicas to: state=S_INIT, prev=0, data_o=0 (m_pat_gen: cnt_o=0, warn_o=0).
REQ-018 Reset asserted mid-operation SHALL abort any state including S_ERR; the first edge after release behaves per REQ-009.

Structure
REQ-019 A shared package SHALL hold the state enum, the ERR code constant (all-ones of N) and the 3-way majority-vote function.
REQ-020 One sub-module, tmr_voter (3-input, N-bit bitwise majority, with disagreement flag), SHALL be used by both dut_fsm and m_pat_gen.

Verification
REQ-021 Reset then release, data_i=0 -> data_o=0 held in reset; first edge after release gives data_o=0 and state S_TRACK.
REQ-022 m_pat_gen with inc_i=1 feeding two chained dut_fsm -> second stage outputs 0,1..14,0,... delayed 2 cycles from cnt_o, never 4'hF.
REQ-023 inj_err_i pulsed for 1 cycle -> warn_o=1 for 1 cycle, cnt_o sequence undisturbed, no 4'hF at either stage.
REQ-024 data_i 3 then 7 then 8 -> data_o=3, then 4'hF (S_ERR), then 8 (S_TRACK); the second stage shows 3, F, 8 one cycle later.
REQ-025 data_i=15 while in S_TRACK -> data_o=4'hF, stays 4'hF while data_i=15, resynchronises on the next value <= 14.
REQ-026 rst_i low asynchronously while in S_ERR -> data_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dut_fsm_pkg.sv
// Shared types and helpers for the sequence-checker FSM and its TMR pattern generator.
package dut_fsm_pkg;

  localparam int unsigned MAX_W   = 32;
  localparam int unsigned STATE_W = 2;

  // All-ones pattern; truncated to N bits it is the error code 2^N-1.
  localparam logic [MAX_W-1:0] ERR_ALL = '1;

  typedef enum logic [STATE_W-1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  function automatic logic [MAX_W-1:0] maj3(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input logic [MAX_W-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/m_pat_gen.sv
// Triplicated wrapping counter; replica 0 can be upset on demand to exercise scrubbing.
module m_pat_gen #(
  parameter int unsigned N   = 4,
  parameter int unsigned LIM = 14
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         inj_err_i,
  output logic [N-1:0] cnt_o,
  output logic         warn_o
);

  logic [N-1:0] cnt_q [3];
  logic [N-1:0] cnt_v;
  logic [N-1:0] cnt_d;
  logic [N-1:0] cnt0_d;

  function automatic logic [N-1:0] wrap_inc(input logic [N-1:0] v);
    return (v == N'(LIM)) ? '0 : v + N'(1);
  endfunction

  tmr_voter #(.W(N)) u_vote_cnt (
    .a_i       (cnt_q[0]),
    .b_i       (cnt_q[1]),
    .c_i       (cnt_q[2]),
    .vote_o    (cnt_v),
    .mismatch_o(warn_o)
  );

  always_comb begin
    cnt_d  = inc_i ? wrap_inc(cnt_v) : cnt_v;
    cnt0_d = inj_err_i ? wrap_inc(cnt_d) : cnt_d;
  end

  // Every replica reloads from the voted value, so an upset lasts one cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q[0] <= cnt0_d;
      cnt_q[1] <= cnt_d;
      cnt_q[2] <= cnt_d;
    end
  end

  assign cnt_o = cnt_v;

endmodule

// File: rtl/tmr_voter.sv
// Three-way bitwise majority voter with a replica-disagreement flag.
module tmr_voter
  import dut_fsm_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] vote_o,
  output logic         mismatch_o
);

  assign vote_o     = W'(maj3(MAX_W'(a_i), MAX_W'(b_i), MAX_W'(c_i)));
  assign mismatch_o = (a_i != b_i) || (a_i != c_i);

endmodule

// File: rtl/dut_fsm.sv
// Sequence checker: accepts hold or +1 (wrapping at LIM) steps, flags anything else
// with the all-ones error code. State, prev and output are TMR-protected.
module dut_fsm
  import dut_fsm_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned LIM = 14
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] data_i,
  output logic [N-1:0] data_o
);

  localparam logic [N-1:0] ERR   = N'(ERR_ALL);
  localparam logic [N-1:0] LIM_V = N'(LIM);

  state_t             state_q [3];
  logic [N-1:0]       prev_q  [3];
  logic [N-1:0]       out_q   [3];
  state_t             state_d;
  logic [N-1:0]       prev_d;
  logic [N-1:0]       out_d;
  logic [STATE_W-1:0] state_vote;
  state_t             state_v;
  logic [N-1:0]       prev_v;
  logic [N-1:0]       out_v;
  logic [2:0]         mismatch_unused;
  logic               in_range;
  logic               legal_step;
  logic               accept;

  tmr_voter #(.W(STATE_W)) u_vote_state (
    .a_i(state_q[0]), .b_i(state_q[1]), .c_i(state_q[2]),
    .vote_o(state_vote), .mismatch_o(mismatch_unused[0])
  );
  tmr_voter #(.W(N)) u_vote_prev (
    .a_i(prev_q[0]), .b_i(prev_q[1]), .c_i(prev_q[2]),
    .vote_o(prev_v), .mismatch_o(mismatch_unused[1])
  );
  tmr_voter #(.W(N)) u_vote_out (
    .a_i(out_q[0]), .b_i(out_q[1]), .c_i(out_q[2]),
    .vote_o(out_v), .mismatch_o(mismatch_unused[2])
  );

  assign state_v    = state_t'(state_vote);
  assign in_range   = (data_i <= LIM_V);
  assign legal_step = (data_i == prev_v) ||
                      (data_i == ((prev_v == LIM_V) ? '0 : prev_v + N'(1)));

  // State register: all replicas reload from the voted next value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_INIT;
        prev_q[i]  <= '0;
        out_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d;
        prev_q[i]  <= prev_d;
        out_q[i]   <= out_d;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_v;
    case (state_v)
      S_INIT, S_ERR: if (in_range) state_d = S_TRACK;
      S_TRACK:       state_d = legal_step ? S_TRACK : S_ERR;
      default:       state_d = S_INIT;
    endcase
  end

  // Output and prev update; INIT and ERR both resynchronise on any in-range value.
  always_comb begin
    prev_d = prev_v;
    out_d  = ERR;
    accept = (state_v == S_TRACK) ? legal_step : in_range;
    if (accept) begin
      prev_d = data_i;
      out_d  = data_i;
    end
  end

  assign data_o = out_v;

endmodule

// File: tb/tb_dut_fsm.sv
// Pattern generator feeding two chained checkers, scored against a lock/last-value model.
module tb_dut_fsm;

  localparam int LIM = 14;
  localparam int ERR = 15;

  typedef struct {
    logic [3:0] e1;
    logic [3:0] e2;
    logic [3:0] cnt;
    logic       warn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tb_data = '0;
  logic       sel_gen = 1'b0;
  logic       inc = 1'b0;
  logic       inj = 1'b0;
  logic [3:0] cnt, din1, d1, d2;
  logic       warn;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  bit lk1, lk2;
  int last1, last2, out1, cnt_m;

  always #5 clk = ~clk;

  assign din1 = sel_gen ? cnt : tb_data;

  m_pat_gen #(.N(4), .LIM(14)) u_gen (
    .clk_i(clk), .rst_i(rst_n), .inc_i(inc), .inj_err_i(inj),
    .cnt_o(cnt), .warn_o(warn)
  );
  dut_fsm #(.N(4), .LIM(14)) u_s1 (
    .clk_i(clk), .rst_i(rst_n), .data_i(din1), .data_o(d1)
  );
  dut_fsm #(.N(4), .LIM(14)) u_s2 (
    .clk_i(clk), .rst_i(rst_n), .data_i(d1), .data_o(d2)
  );

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Checker seen as "locked to last accepted value" or not.
  function automatic int fstep(input int d, inout bit lk, inout int last);
    if (!lk) begin
      if (d <= LIM) begin
        lk = 1'b1;
        last = d;
        return d;
      end
      return ERR;
    end
    if (d == last || d == (last + 1) % (LIM + 1)) begin
      last = d;
      return d;
    end
    lk = 1'b0;
    return ERR;
  endfunction

  task automatic cyc(input int d, input bit sg, input bit inc_v, input bit inj_v);
    int din, o1, o2;
    exp_t e;
    @(negedge clk);
    rst_n   = 1'b1;
    tb_data = 4'(d);
    sel_gen = sg;
    inc     = inc_v;
    inj     = inj_v;
    din = sg ? cnt_m : d;
    o2 = fstep(out1, lk2, last2);
    o1 = fstep(din, lk1, last1);
    out1 = o1;
    if (inc_v) cnt_m = (cnt_m == LIM) ? 0 : cnt_m + 1;
    e.e1 = 4'(o1);
    e.e2 = 4'(o2);
    e.cnt = 4'(cnt_m);
    e.warn = inj_v;
    q.push_back(e);
  endtask

  // Asserted away from any clock edge; outputs must clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    lk1 = 0; lk2 = 0; last1 = 0; last2 = 0; out1 = 0; cnt_m = 0;
    #1;
    chk("rst_async_s1", d1, 4'h0);
    chk("rst_async_s2", d2, 4'h0);
    chk("rst_async_cnt", cnt, 4'h0);
    chk("rst_async_warn", {3'b0, warn}, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_s1", d1, 4'h0);
    chk("rst_hold_s2", d2, 4'h0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk("stage1", d1, e.e1);
      chk("stage2", d2, e.e2);
      chk("cnt", cnt, e.cnt);
      chk("warn", {3'b0, warn}, {3'b0, e.warn});
    end
  end

  initial begin
    int d, r;
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);

    do_reset();
    cyc(3, 0, 0, 0);
    cyc(7, 0, 0, 0);
    cyc(8, 0, 0, 0);
    cyc(9, 0, 0, 0);
    cyc(15, 0, 0, 0);
    cyc(15, 0, 0, 0);
    cyc(15, 0, 0, 0);
    cyc(10, 0, 0, 0);
    cyc(14, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(11, 0, 0, 0);
    cyc(15, 0, 0, 0);
    do_reset();
    cyc(5, 0, 0, 0);
    cyc(6, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 7);
      if (r < 4)      d = lk1 ? (last1 + 1) % (LIM + 1) : $urandom_range(0, LIM);
      else if (r < 6) d = last1;
      else            d = $urandom_range(0, 15);
      cyc(d, 0, 0, 0);
    end

    do_reset();
    for (int i = 0; i < 60; i++) cyc(0, 1, 1, (i % 17) == 5);
    for (int i = 0; i < 80; i++)
      cyc(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 4'(q.size()), 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
